udp_frame_tx: RTL

- Transmit-side counterpart of the receive-path byte-stream UDP matcher.
- Accepts a payload-length command plus an 8-bit payload stream, and emits a complete Ethernet II / IPv4 / UDP frame (no FCS) on an 8-bit valid/ready/last byte stream toward the MAC.
- Payload occupies frame byte 42 onward, the same offset the receive path uses; the destination UDP port comes from the same ctrl_reg[15:0] field the receive path matches on.
- Computes the IPv4 header checksum, tracks the IP identification field, and enforces the 60-byte minimum frame.

---
 rtl/udp_pkt_pkg.sv | 24 ++
 rtl/ipv4_csum.sv | 29 ++
 rtl/udp_frame_tx.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/udp_pkt_pkg.sv
// Shared UDP/IPv4/Ethernet framing definitions for the transmit and receive paths.
package udp_pkt_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CALC,
    HDR,
    PAY,
    PAD,
    DRAIN,
    DONE
  } state_e;

  localparam int          ETH_HDR_LEN    = 14;
  localparam int          IP_HDR_LEN     = 20;
  localparam int          UDP_HDR_LEN    = 8;
  localparam int          PAYLOAD_OFS    = 42;
  localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;
  localparam logic [7:0]  IP_PROTO_UDP   = 8'h11;
  localparam logic [10:0] MAX_PAYLOAD    = 11'd1472;
  localparam logic [7:0]  IP_VER_IHL     = 8'h45;
  localparam logic [15:0] IP_FLAGS_DF    = 16'h4000;

endpackage

// File: rtl/ipv4_csum.sv
// Combinational IPv4 header checksum: ones'-complement sum of the header words,
// carry folded twice, then inverted.
module ipv4_csum
  import udp_pkt_pkg::*;
(
  input  logic [15:0] totalLen_i,
  input  logic [15:0] ipId_i,
  input  logic [7:0]  ttl_i,
  input  logic [31:0] srcIp_i,
  input  logic [31:0] dstIp_i,
  output logic [15:0] csum_o
);

  logic [19:0] sum;
  logic [16:0] fold1;
  logic [15:0] fold2;

  // Nine 16-bit words fit comfortably in 20 bits, so no carry is lost before folding.
  always_comb begin
    sum = 20'({IP_VER_IHL, 8'h00}) + 20'(totalLen_i) + 20'(ipId_i) + 20'(IP_FLAGS_DF)
        + 20'({ttl_i, IP_PROTO_UDP})
        + 20'(srcIp_i[31:16]) + 20'(srcIp_i[15:0])
        + 20'(dstIp_i[31:16]) + 20'(dstIp_i[15:0]);
    fold1  = {1'b0, sum[15:0]} + {13'b0, sum[19:16]};
    fold2  = fold1[15:0] + {15'b0, fold1[16]};
    csum_o = ~fold2;
  end

endmodule

// File: rtl/udp_frame_tx.sv
// Builds an Ethernet II / IPv4 / UDP frame (no FCS) around a streamed payload,
// padding to the minimum frame size and reconciling payload length mismatches.
module udp_frame_tx
  import udp_pkt_pkg::*;
#(
  parameter logic [47:0] SRC_MAC   = 48'h02_00_00_00_00_01,
  parameter logic [47:0] DST_MAC   = 48'hFF_FF_FF_FF_FF_FF,
  parameter logic [7:0]  TTL       = 8'd64,
  parameter int          MIN_FRAME = 60
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] ctrl_reg,
  input  logic [15:0] src_port,
  input  logic [31:0] src_ip,
  input  logic [31:0] dst_ip,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [10:0] cmd_len,
  input  logic [7:0]  s_data,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic        s_last,
  output logic [7:0]  m_data,
  output logic        m_valid,
  input  logic        m_ready,
  output logic        m_last,
  output logic        err_len
);

  state_e      state_q, state_d;
  logic [10:0] len_q, len_d;
  logic [15:0] dstPort_q, dstPort_d;
  logic [15:0] srcPort_q, srcPort_d;
  logic [31:0] srcIp_q, srcIp_d;
  logic [31:0] dstIp_q, dstIp_d;
  logic [15:0] ipId_q, ipId_d;
  logic [15:0] csum_q, csum_d;
  logic [5:0]  byteCnt_q, byteCnt_d;
  logic [10:0] payCnt_q, payCnt_d;
  logic        short_q, short_d;
  logic        drainAfter_q, drainAfter_d;
  logic        errLen_q;
  logic        errSet;

  logic [15:0]  totalLen;
  logic [15:0]  udpLen;
  logic [15:0]  csumCalc;
  logic         needPad;
  logic         isLenByte;
  logic         padLast;
  logic [335:0] hdrVec;
  logic [335:0] hdrShift;
  logic [15:0]  unusedCtrl;

  assign unusedCtrl = ctrl_reg[31:16];

  assign totalLen  = 16'(len_q) + 16'(IP_HDR_LEN + UDP_HDR_LEN);
  assign udpLen    = 16'(len_q) + 16'(UDP_HDR_LEN);
  assign needPad   = (12'(PAYLOAD_OFS) + {1'b0, len_q}) < 12'(MIN_FRAME);
  assign isLenByte = (payCnt_q == (len_q - 11'd1));
  assign padLast   = (payCnt_q == 11'(MIN_FRAME - PAYLOAD_OFS - 1));

  // Header bytes 0..41 packed MSB-first so byte N is the top byte after shifting by N.
  assign hdrVec = {DST_MAC, SRC_MAC, ETHERTYPE_IPV4,
                   IP_VER_IHL, 8'h00, totalLen, ipId_q, IP_FLAGS_DF,
                   TTL, IP_PROTO_UDP, csum_q, srcIp_q, dstIp_q,
                   srcPort_q, dstPort_q, udpLen, 16'h0000};
  assign hdrShift = hdrVec << {byteCnt_q, 3'b000};

  ipv4_csum u_csum (
    .totalLen_i (totalLen),
    .ipId_i     (ipId_q),
    .ttl_i      (TTL),
    .srcIp_i    (srcIp_q),
    .dstIp_i    (dstIp_q),
    .csum_o     (csumCalc)
  );

  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    dstPort_d    = dstPort_q;
    srcPort_d    = srcPort_q;
    srcIp_d      = srcIp_q;
    dstIp_d      = dstIp_q;
    ipId_d       = ipId_q;
    csum_d       = csum_q;
    byteCnt_d    = byteCnt_q;
    payCnt_d     = payCnt_q;
    short_d      = short_q;
    drainAfter_d = drainAfter_q;
    errSet       = 1'b0;
    cmd_ready    = 1'b0;
    s_ready      = 1'b0;
    m_valid      = 1'b0;
    m_last       = 1'b0;
    m_data       = 8'h00;

    unique case (state_q)
      IDLE: begin
        cmd_ready    = 1'b1;
        byteCnt_d    = '0;
        payCnt_d     = '0;
        short_d      = 1'b0;
        drainAfter_d = 1'b0;
        if (cmd_valid) begin
          if (cmd_len == 11'd0)             len_d = 11'd1;
          else if (cmd_len > MAX_PAYLOAD)   len_d = MAX_PAYLOAD;
          else                              len_d = cmd_len;
          dstPort_d = ctrl_reg[15:0];
          srcPort_d = src_port;
          srcIp_d   = src_ip;
          dstIp_d   = dst_ip;
          state_d   = CALC;
        end
      end

      CALC: begin
        csum_d  = csumCalc;
        state_d = HDR;
      end

      HDR: begin
        m_valid = 1'b1;
        m_data  = hdrShift[335:328];
        if (m_ready) begin
          if (byteCnt_q == 6'(PAYLOAD_OFS - 1)) state_d = PAY;
          else                                  byteCnt_d = byteCnt_q + 6'd1;
        end
      end

      PAY: begin
        if (short_q) begin
          // Source ended early: fill the promised payload positions with zeros.
          m_valid = 1'b1;
          m_last  = isLenByte && !needPad;
          if (m_ready) begin
            payCnt_d = payCnt_q + 11'd1;
            if (isLenByte) state_d = needPad ? PAD : DONE;
          end
        end else begin
          m_data  = s_data;
          m_valid = s_valid;
          s_ready = m_ready;
          m_last  = s_valid && isLenByte && !needPad;
          if (s_valid && m_ready) begin
            payCnt_d = payCnt_q + 11'd1;
            if (isLenByte) begin
              errSet = !s_last;
              if (needPad) begin
                drainAfter_d = !s_last;
                state_d      = PAD;
              end else begin
                state_d = s_last ? DONE : DRAIN;
              end
            end else if (s_last) begin
              errSet  = 1'b1;
              short_d = 1'b1;
            end
          end
        end
      end

      PAD: begin
        m_valid = 1'b1;
        m_last  = padLast;
        if (m_ready) begin
          payCnt_d = payCnt_q + 11'd1;
          if (padLast) state_d = drainAfter_q ? DRAIN : DONE;
        end
      end

      DRAIN: begin
        s_ready = 1'b1;
        if (s_valid && s_last) state_d = DONE;
      end

      DONE: begin
        ipId_d  = ipId_q + 16'd1;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      len_q        <= 11'd1;
      dstPort_q    <= '0;
      srcPort_q    <= '0;
      srcIp_q      <= '0;
      dstIp_q      <= '0;
      ipId_q       <= '0;
      csum_q       <= '0;
      byteCnt_q    <= '0;
      payCnt_q     <= '0;
      short_q      <= 1'b0;
      drainAfter_q <= 1'b0;
      errLen_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      dstPort_q    <= dstPort_d;
      srcPort_q    <= srcPort_d;
      srcIp_q      <= srcIp_d;
      dstIp_q      <= dstIp_d;
      ipId_q       <= ipId_d;
      csum_q       <= csum_d;
      byteCnt_q    <= byteCnt_d;
      payCnt_q     <= payCnt_d;
      short_q      <= short_d;
      drainAfter_q <= drainAfter_d;
      errLen_q     <= errSet;
    end
  end

  assign err_len = errLen_q;

endmodule
